// File: rtl/cg_rv_issue_scoreboard_pkg.sv
// RV32I instruction-field helpers and issue-stage types shared by the scoreboard
// and by any forwarding logic that needs the same register-use decode.
package cg_rv_issue_scoreboard_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {ST_EMPTY, ST_HELD} iss_state_e;

    function automatic logic [6:0] opcode_f(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] rd_f(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] rs1_f(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_f(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic is_rd_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
               (opc == OPC_LUI)  || (opc == OPC_AUIPC)  || (opc == OPC_JAL) ||
               (opc == OPC_JALR);
    endfunction

    function automatic logic uses_rs1_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

    function automatic logic uses_rs2_opcode(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // x0 destinations are architectural no-ops, so they never claim the scoreboard.
    function automatic logic writes_rd(input logic [31:0] instr);
        return is_rd_opcode(opcode_f(instr)) && (rd_f(instr) != 5'd0);
    endfunction

endpackage

// File: rtl/cg_rv_issue_scoreboard_scoreboard.sv
// Pending-write bit per architectural register: set on issue, clear on writeback,
// set wins on collision, x0 hardwired to zero, plus a writeback-bypassed read view.
module cg_rv_scoreboard #(
    parameter int WB_BYPASS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr_en,
    input  logic [4:0]  i_clr_idx,
    input  logic        i_set_en,
    input  logic [4:0]  i_set_idx,
    output logic [31:0] o_pending,
    output logic [31:0] o_eff_pend
);

    logic [31:0] pend_q, pend_d;
    logic [31:0] byp_mask;

    always_comb begin
        pend_d = pend_q;
        if (i_clr_en) pend_d[i_clr_idx] = 1'b0;
        if (i_set_en) pend_d[i_set_idx] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    // With bypass, a register being written back this cycle already looks free.
    assign byp_mask   = ((WB_BYPASS != 0) && i_clr_en) ? (32'd1 << i_clr_idx) : 32'd0;
    assign o_eff_pend = pend_q & ~byp_mask;
    assign o_pending  = pend_q;

endmodule

// File: rtl/cg_rv_issue_scoreboard.sv
// Decode-to-issue hazard controller: one-entry issue register that holds an
// instruction until its source/destination registers have no write in flight.
module cg_rv_issue_scoreboard
    import cg_rv_issue_scoreboard_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int STALL_CW  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dec_valid,
    output logic                o_dec_ready,
    input  logic [31:0]         i_dec_instr,
    output logic                o_iss_valid,
    input  logic                i_iss_ready,
    output logic [31:0]         o_iss_instr,
    input  logic                i_wb_valid,
    input  logic [4:0]          i_wb_rd,
    input  logic                i_flush,
    output logic [31:0]         o_pending,
    output logic [STALL_CW-1:0] o_stall_cnt
);

    iss_state_e          state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [STALL_CW-1:0] stall_q, stall_d;
    logic [31:0]         eff_pend;
    logic [6:0]          opc;
    logic [4:0]          rs1, rs2, rd;
    logic                u_rs1, u_rs2, w_rd;
    logic                hold_vld, hazard, iss_fire, dec_fire;

    assign opc   = opcode_f(instr_q);
    assign rs1   = rs1_f(instr_q);
    assign rs2   = rs2_f(instr_q);
    assign rd    = rd_f(instr_q);
    assign u_rs1 = uses_rs1_opcode(opc);
    assign u_rs2 = uses_rs2_opcode(opc);
    assign w_rd  = writes_rd(instr_q);

    cg_rv_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr_en   (i_wb_valid),
        .i_clr_idx  (i_wb_rd),
        .i_set_en   (iss_fire & w_rd),
        .i_set_idx  (rd),
        .o_pending  (o_pending),
        .o_eff_pend (eff_pend)
    );

    assign hold_vld    = (state_q == ST_HELD);
    assign hazard      = (u_rs1 & eff_pend[rs1]) | (u_rs2 & eff_pend[rs2]) | (w_rd & eff_pend[rd]);
    assign o_iss_valid = hold_vld & ~hazard & ~i_flush;
    assign iss_fire    = o_iss_valid & i_iss_ready;
    // Flush blocks intake so the beat arriving alongside it is not silently lost.
    assign o_dec_ready = (~hold_vld | iss_fire) & ~i_flush;
    assign dec_fire    = i_dec_valid & o_dec_ready;
    assign o_iss_instr = instr_q;
    assign o_stall_cnt = stall_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_EMPTY: begin
                if (dec_fire) begin
                    state_d = ST_HELD;
                    instr_d = i_dec_instr;
                end
            end
            ST_HELD: begin
                if (i_flush) begin
                    state_d = ST_EMPTY;
                end else if (dec_fire) begin
                    instr_d = i_dec_instr;
                end else if (iss_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (hold_vld && hazard && !i_flush && (stall_q != {STALL_CW{1'b1}}))
            stall_d = stall_q + STALL_CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_cg_rv_issue_scoreboard.sv
// Directed cycle vectors for the issue scoreboard plus hand sequences for
// counter saturation, mid-stall reset and the non-bypass writeback timing.
module tb_cg_rv_issue_scoreboard;

    localparam int SCW = 4;

    logic        clk, rst_n, dv, ir, wv, fl;
    logic [31:0] di;
    logic [4:0]  wrd;
    logic        rdy, iv, rdy0, iv0;
    logic [31:0] instr, pend, instr0, pend0;
    logic [SCW-1:0] stall, stall0;

    int total = 0;
    int bad   = 0;

    cg_rv_issue_scoreboard #(.WB_BYPASS(1), .STALL_CW(SCW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(dv), .o_dec_ready(rdy),
        .i_dec_instr(di), .o_iss_valid(iv), .i_iss_ready(ir), .o_iss_instr(instr),
        .i_wb_valid(wv), .i_wb_rd(wrd), .i_flush(fl), .o_pending(pend),
        .o_stall_cnt(stall)
    );

    cg_rv_issue_scoreboard #(.WB_BYPASS(0), .STALL_CW(SCW)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(dv), .o_dec_ready(rdy0),
        .i_dec_instr(di), .o_iss_valid(iv0), .i_iss_ready(ir), .o_iss_instr(instr0),
        .i_wb_valid(wv), .i_wb_rd(wrd), .i_flush(fl), .o_pending(pend0),
        .o_stall_cnt(stall0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           dv;
        logic [31:0]    di;
        logic           ir, wv;
        logic [4:0]     wrd;
        logic           fl;
        logic           e_rdy, e_iv;
        logic [31:0]    e_instr, e_pend;
        logic [SCW-1:0] e_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        logic [4:0] a, b, c;
        a = rd[4:0]; b = rs1[4:0]; c = rs2[4:0];
        return {7'b0, c, b, 3'b000, a, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1,
                                          input logic [2:0] f3, input logic [11:0] imm);
        logic [4:0] a, b;
        a = rd[4:0]; b = rs1[4:0];
        return {imm, b, f3, a, op};
    endfunction

    function automatic logic [31:0] enc_sw(input int base, input int src);
        logic [4:0] a, b;
        a = base[4:0]; b = src[4:0];
        return {7'b0, b, a, 3'b010, 5'b0, 7'h23};
    endfunction

    function automatic void row(input logic v, input logic [31:0] i, input logic r,
                                input logic w, input int wr, input logic f,
                                input logic erdy, input logic eiv, input logic [31:0] einstr,
                                input logic [31:0] epend, input int est);
        vec_t x;
        x.dv = v; x.di = i; x.ir = r; x.wv = w; x.wrd = wr[4:0]; x.fl = f;
        x.e_rdy = erdy; x.e_iv = eiv; x.e_instr = einstr; x.e_pend = epend;
        x.e_stall = est[SCW-1:0];
        tbl.push_back(x);
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic r,
                         input logic w, input logic [4:0] wr, input logic f);
        @(negedge clk);
        dv = v; di = i; ir = r; wv = w; wrd = wr; fl = f;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; dv = 0; di = '0; ir = 0; wv = 0; wrd = '0; fl = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] A, B, I1, I2, I3, I4, L7, W7, W7b, X0, SW, D11;

    initial begin
        rst_n = 1'b0; dv = 0; di = '0; ir = 0; wv = 0; wrd = '0; fl = 0;

        A   = enc_r(5, 1, 2);
        B   = enc_r(6, 5, 3);
        I1  = enc_i(7'h13, 1, 0, 3'b000, 12'd1);
        I2  = enc_i(7'h13, 2, 0, 3'b000, 12'd2);
        I3  = enc_i(7'h13, 3, 0, 3'b000, 12'd3);
        I4  = enc_i(7'h13, 4, 0, 3'b000, 12'd4);
        L7  = enc_i(7'h03, 7, 1, 3'b010, 12'd0);
        W7  = enc_i(7'h13, 7, 0, 3'b000, 12'd1);
        W7b = enc_i(7'h13, 7, 0, 3'b000, 12'd2);
        X0  = enc_i(7'h13, 0, 0, 3'b000, 12'd1);
        SW  = enc_sw(3, 2);
        D11 = enc_r(5, 1, 1);

        //   dv di  ir wv wrd fl | rdy iv instr pend  stall
        row(0, 0,   0, 0, 0, 0,   1, 0, 0,   32'h00, 0);  // reset state
        // RAW: add x5 then add x6,x5 stalls until wb x5
        row(1, A,   1, 0, 0, 0,   1, 0, 0,   32'h00, 0);
        row(1, B,   1, 0, 0, 0,   1, 1, A,   32'h00, 0);
        row(0, 0,   1, 0, 0, 0,   0, 0, B,   32'h20, 0);
        row(0, 0,   1, 0, 0, 0,   0, 0, B,   32'h20, 1);
        row(0, 0,   1, 1, 5, 0,   1, 1, B,   32'h20, 2);
        row(0, 0,   1, 0, 0, 0,   1, 0, B,   32'h40, 2);
        row(0, 0,   1, 1, 6, 0,   1, 0, B,   32'h40, 2);
        // independent addi x1..x4 back to back
        row(1, I1,  1, 0, 0, 0,   1, 0, B,   32'h00, 2);
        row(1, I2,  1, 0, 0, 0,   1, 1, I1,  32'h00, 2);
        row(1, I3,  1, 0, 0, 0,   1, 1, I2,  32'h02, 2);
        row(1, I4,  1, 0, 0, 0,   1, 1, I3,  32'h06, 2);
        row(0, 0,   1, 0, 0, 0,   1, 1, I4,  32'h0E, 2);
        row(0, 0,   1, 1, 1, 0,   1, 0, I4,  32'h1E, 2);
        row(0, 0,   1, 1, 2, 0,   1, 0, I4,  32'h1C, 2);
        row(0, 0,   1, 1, 3, 0,   1, 0, I4,  32'h18, 2);
        row(0, 0,   1, 1, 4, 0,   1, 0, I4,  32'h10, 2);
        // WAW on x7, then wb x7 coinciding with a new x7 writer issuing
        row(1, L7,  1, 0, 0, 0,   1, 0, I4,  32'h00, 2);
        row(1, W7,  1, 0, 0, 0,   1, 1, L7,  32'h00, 2);
        row(0, 0,   1, 0, 0, 0,   0, 0, W7,  32'h80, 2);
        row(1, W7b, 1, 1, 7, 0,   1, 1, W7,  32'h80, 3);
        row(0, 0,   1, 0, 0, 0,   0, 0, W7b, 32'h80, 3);
        row(0, 0,   1, 1, 7, 0,   1, 1, W7b, 32'h80, 4);
        row(0, 0,   1, 1, 7, 0,   1, 0, W7b, 32'h80, 4);
        // x0 writer and store: no pending bits; store waits on pending x2
        row(1, X0,  1, 0, 0, 0,   1, 0, W7b, 32'h00, 4);
        row(1, SW,  1, 0, 0, 0,   1, 1, X0,  32'h00, 4);
        row(0, 0,   1, 0, 0, 0,   1, 1, SW,  32'h00, 4);
        row(0, 0,   1, 0, 0, 0,   1, 0, SW,  32'h00, 4);
        row(1, I2,  1, 0, 0, 0,   1, 0, SW,  32'h00, 4);
        row(1, SW,  1, 0, 0, 0,   1, 1, I2,  32'h00, 4);
        row(0, 0,   1, 0, 0, 0,   0, 0, SW,  32'h04, 4);
        // flush while stalled: upstream beat refused, scoreboard kept
        row(1, I1,  1, 0, 0, 1,   0, 0, SW,  32'h04, 5);
        row(0, 0,   1, 0, 0, 0,   1, 0, SW,  32'h04, 5);
        row(0, 0,   1, 1, 2, 0,   1, 0, SW,  32'h04, 5);
        row(0, 0,   1, 0, 0, 0,   1, 0, SW,  32'h00, 5);

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].dv, tbl[k].di, tbl[k].ir, tbl[k].wv, tbl[k].wrd, tbl[k].fl);
            total++;
            if ({rdy, iv, instr, pend, stall} !==
                {tbl[k].e_rdy, tbl[k].e_iv, tbl[k].e_instr, tbl[k].e_pend, tbl[k].e_stall}) begin
                bad++;
                $display("FAIL row%0d: got rdy=%0b vld=%0b instr=%h pend=%h stall=%0d want rdy=%0b vld=%0b instr=%h pend=%h stall=%0d",
                         k, rdy, iv, instr, pend, stall, tbl[k].e_rdy, tbl[k].e_iv,
                         tbl[k].e_instr, tbl[k].e_pend, tbl[k].e_stall);
            end
        end

        // Non-bypass instance: wb in cycle N unblocks only in N+1
        do_reset();
        drive(1, A, 1, 0, 0, 0);
        drive(1, B, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("nobyp_stalled", {63'd0, iv0}, 64'd0);
        drive(0, 0, 1, 1, 5, 0);
        chk("nobyp_wb_cycle", {63'd0, iv0}, 64'd0);
        chk("byp_wb_cycle", {63'd0, iv}, 64'd1);
        drive(0, 0, 1, 0, 0, 0);
        chk("nobyp_next_cycle", {31'd0, iv0, instr0}, {31'd0, 1'b1, B});

        // Stall counter saturation, then reset mid-stall
        do_reset();
        drive(1, I1, 1, 0, 0, 0);
        drive(1, D11, 1, 0, 0, 0);
        for (int c = 0; c < (1 << SCW) + 3; c++) drive(0, 0, 1, 0, 0, 0);
        chk("stall_sat", {59'd0, iv, stall}, {59'd0, 1'b0, {SCW{1'b1}}});
        chk("stall_sat_pend", {32'd0, pend}, 64'h2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_mid_stall", {25'd0, rdy, iv, instr, pend[2:0], stall},
            {25'd0, 1'b1, 1'b0, 32'd0, 3'd0, {SCW{1'b0}}});
        chk("reset_pend", {32'd0, pend}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
